// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
// Holds the default RAM geometry, the FSM state encoding and small decode
// helpers that turn a state into the CPU-side control levels.
package prog_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

  // FSM state encoding (plain constants so older tools can consume them).
  localparam int unsigned StateW = 3;
  typedef logic [StateW-1:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StLoad = 3'd1;
  localparam state_t StArm  = 3'd2;
  localparam state_t StRun  = 3'd3;
  localparam state_t StHalt = 3'd4;

  // RAM is handed to the CPU port from ARM onwards.
  function automatic logic state_run_mode(state_t s);
    return (s == StArm) || (s == StRun) || (s == StHalt);
  endfunction

  // CPU core is held in reset until the loader releases it into RUN.
  function automatic logic state_cpu_reset(state_t s);
    return (s == StIdle) || (s == StLoad) || (s == StArm);
  endfunction

endpackage

// File: rtl/ld_addr_counter.sv
// Load-address pointer for the program loader.
// Ports:
//   clk_i, rst_i    clock and asynchronous active-high reset
//   load_i          latch last_addr_i as the final address and restart at 0
//   clear_i         restart the pointer at 0 (final address kept)
//   inc_i           advance after a beat; saturates at the final address
//   last_addr_i     final address to latch on load_i
//   ptr_o           current write address
//   last_o          pointer equals the latched final address
module ld_addr_counter
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              inc_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              at_last;

  assign at_last = (ptr_q == last_addr_q);

  always_comb begin
    ptr_d       = ptr_q;
    last_addr_d = last_addr_q;
    if (load_i) begin
      ptr_d       = '0;
      last_addr_d = last_addr_i;
    end else if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i && !at_last) begin
      // Holding at the final address keeps a full-depth load from wrapping to 0.
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      last_addr_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = at_last;

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams a program image into the CPU RAM through the
// programming port, then hands the RAM to the CPU and releases its reset.
// Ports:
//   clk_i, rst_i          clock and asynchronous active-high reset
//   start_i, count_i      load request and last address to load (0..count_i)
//   in_valid_i, in_data_i program byte stream; in_ready_o accepts it
//   cpu_stop_i            CPU executed HLT
//   ram_addr_o/data_o/we_o  registered programming-port write
//   run_mode_o            RAM mux: 0 programming port, 1 CPU port
//   cpu_reset_o           reset to the CPU core
//   busy_o                loading or arming
//   done_o                one-cycle pulse on release into RUN
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] count_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  input  logic              cpu_stop_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_we_o,
  output logic              run_mode_o,
  output logic              cpu_reset_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned SettleW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYC - 1);

  state_t state_q, state_d;

  logic [SettleW-1:0] settle_q, settle_d;
  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_data_q, ram_data_d;
  logic               ram_we_q, ram_we_d;
  logic               run_mode_q, run_mode_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               done_q, done_d;

  logic              beat;
  logic              accept_start;
  logic              ptr_last;
  logic [ADDR_W-1:0] ptr;

  // Ready is a pure state decode so a beat is known in the same cycle.
  assign in_ready_o   = (state_q == StLoad);
  assign busy_o       = (state_q == StLoad) || (state_q == StArm);
  assign beat         = in_valid_i && in_ready_o;
  assign accept_start = start_i && ((state_q == StIdle) || (state_q == StHalt));

  ld_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (accept_start),
    .clear_i     (state_q == StIdle),
    .inc_i       (beat),
    .last_addr_i (count_i),
    .ptr_o       (ptr),
    .last_o      (ptr_last)
  );

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      StIdle: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
        settle_d = '0;
        if (beat && ptr_last) state_d = StArm;
      end
      StArm: begin
        if (settle_q == SettleLast) begin
          state_d = StRun;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StRun: begin
        // A simultaneous Start is dropped: HALT only sees Start in later cycles.
        if (cpu_stop_i) state_d = StHalt;
      end
      StHalt: begin
        if (start_i) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with
  // the state register rather than trailing it by a cycle.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    ram_we_d    = 1'b0;
    if (beat) begin
      ram_addr_d = ptr;
      ram_data_d = in_data_i;
      ram_we_d   = 1'b1;
    end
    run_mode_d  = state_run_mode(state_d);
    cpu_reset_d = state_cpu_reset(state_d);
    done_d      = (state_q == StArm) && (state_d == StRun);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      settle_q    <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_we_q    <= 1'b0;
      run_mode_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_we_q    <= ram_we_d;
      run_mode_q  <= run_mode_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign ram_data_o  = ram_data_q;
  assign ram_we_o    = ram_we_q;
  assign run_mode_o  = run_mode_q;
  assign cpu_reset_o = cpu_reset_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a scoreboard queue of expected RAM
// writes is filled as beats are driven and drained as writes appear.
module tb_prog_loader;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [3:0] count_i;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic       cpu_stop_i;
  logic [3:0] ram_addr_o;
  logic [7:0] ram_data_o;
  logic       ram_we_o;
  logic       run_mode_o;
  logic       cpu_reset_o;
  logic       busy_o;
  logic       done_o;

  prog_loader #(
    .ADDR_W     (4),
    .DATA_W     (8),
    .SETTLE_CYC (1)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .count_i     (count_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .cpu_stop_i  (cpu_stop_i),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_we_o    (ram_we_o),
    .run_mode_o  (run_mode_o),
    .cpu_reset_o (cpu_reset_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;
  int wcnt    = 0;
  logic [11:0] exp_q[$];  // {addr, data}

  logic [7:0] img [16] = '{8'hBF, 8'h0E, 8'hE0, 8'h4F, 8'h2E, 8'h4D, 8'h1E, 8'hE0,
                           8'h3F, 8'h7D, 8'h60, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h01};

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Write monitor: every visible write must match the oldest expected beat.
  always @(negedge clk_i) begin
    if (ram_we_o === 1'b1) begin
      wcnt++;
      if (exp_q.size() == 0) begin
        check("unexp_we", 1, 0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("wr_addr", int'(ram_addr_o), int'(e[11:8]));
        check("wr_data", int'(ram_data_o), int'(e[7:0]));
      end
    end
  end

  task automatic check_ctrl(input string tag, input bit rdy, input bit bsy, input bit rm,
                            input bit cr, input bit dn);
    check({tag, "_ready"}, int'(in_ready_o), int'(rdy));
    check({tag, "_busy"}, int'(busy_o), int'(bsy));
    check({tag, "_runmode"}, int'(run_mode_o), int'(rm));
    check({tag, "_cpurst"}, int'(cpu_reset_o), int'(cr));
    check({tag, "_done"}, int'(done_o), int'(dn));
  endtask

  // Full load from IDLE/HALT through ARM into RUN. poke >= 0 pulses Start
  // (with a different Count) alongside that beat index.
  task automatic load_prog(input int cnt, input bit gap, input int poke, input bit use_img);
    int wbase;
    logic [7:0] d;
    wbase   = wcnt;
    start_i = 1'b1;
    count_i = 4'(cnt);
    tick();
    start_i = 1'b0;
    count_i = 4'hF;
    check_ctrl("load", 1, 1, 0, 1, 0);
    for (int i = 0; i <= cnt; i++) begin
      d          = use_img ? img[i] : 8'($urandom);
      in_valid_i = 1'b1;
      in_data_i  = d;
      exp_q.push_back({4'(i), d});
      if (i == poke) begin
        start_i = 1'b1;
        count_i = 4'(cnt + 5);
      end
      tick();
      start_i = 1'b0;
      if (gap && i < cnt) begin
        in_valid_i = 1'b0;
        in_data_i  = 8'($urandom);
        tick();
      end
    end
    in_valid_i = 1'b0;
    check_ctrl("arm", 0, 1, 1, 1, 0);
    tick();
    check_ctrl("run1", 0, 0, 1, 0, 1);
    tick();
    check_ctrl("run2", 0, 0, 1, 0, 0);
    check("n_writes", wcnt - wbase, cnt + 1);
    check("sb_empty", exp_q.size(), 0);
  endtask

  task automatic do_halt();
    cpu_stop_i = 1'b1;
    tick();
    cpu_stop_i = 1'b0;
    check_ctrl("halt", 0, 0, 1, 0, 0);
  endtask

  initial begin
    int wbase;
    rst_i      = 1'b1;
    start_i    = 1'b0;
    count_i    = '0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    cpu_stop_i = 1'b0;
    #1;
    check_ctrl("rst", 0, 0, 0, 1, 0);
    check("rst_we", int'(ram_we_o), 0);
    check("rst_addr", int'(ram_addr_o), 0);
    check("rst_data", int'(ram_data_o), 0);
    tick();
    tick();
    rst_i = 1'b0;

    // IDLE ignores data and CpuStop until Start.
    in_valid_i = 1'b1;
    cpu_stop_i = 1'b1;
    repeat (3) tick();
    in_valid_i = 1'b0;
    cpu_stop_i = 1'b0;
    check_ctrl("idle", 0, 0, 0, 1, 0);

    // Full 16-byte image, then Start poke in RUN, then Stop+Start together.
    load_prog(15, 1'b0, -1, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_ctrl("run_poke", 0, 0, 1, 0, 0);
    cpu_stop_i = 1'b1;
    start_i    = 1'b1;
    tick();
    cpu_stop_i = 1'b0;
    start_i    = 1'b0;
    check_ctrl("stop_win", 0, 0, 1, 0, 0);
    tick();
    check_ctrl("no_retain", 0, 0, 1, 0, 0);

    // Reload from HALT with two bytes.
    load_prog(1, 1'b0, -1, 1'b0);
    do_halt();

    // Gapped stream with a Start poke mid-load.
    load_prog(3, 1'b1, 1, 1'b0);
    do_halt();

    // Single-byte program.
    load_prog(0, 1'b0, -1, 1'b0);
    do_halt();

    // Reset after the 5th beat of a 16-byte load.
    wbase   = wcnt;
    start_i = 1'b1;
    count_i = 4'd15;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = 8'($urandom);
      exp_q.push_back({4'(i), in_data_i});
      tick();
    end
    rst_i = 1'b1;
    // The 5th write is squashed by reset before the monitor can see it.
    exp_q.delete(exp_q.size() - 1);
    #1;
    check("mrst_we", int'(ram_we_o), 0);
    check_ctrl("mrst", 0, 0, 0, 1, 0);
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (3) tick();
    in_valid_i = 1'b0;
    check_ctrl("post_rst", 0, 0, 0, 1, 0);
    check("mrst_writes", wcnt - wbase, 4);
    check("mrst_sb", exp_q.size(), 0);

    // Loader still works after an aborted load.
    load_prog(2, 1'b0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, 4: RAM address width (16 locations).
REQ-002 Parameter DATA_W, 8: RAM word width (opcode nibble + operand nibble).
REQ-003 Parameter SETTLE_CYC, 1: cycles RunMode is high with CpuReset still asserted before release.
REQ-004 Clock  in  1  single clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high.
REQ-006 Start  in  1  request a program load; sampled only in IDLE and HALT.
REQ-007 Count  in  ADDR_W  last RAM address to load (loads 0..Count); latched on accepted Start.
REQ-008 InValid  in  1  program byte available on InData.
REQ-009 InData  in  DATA_W  program byte.
REQ-010 InReady  out  1  loader accepts a byte this cycle.
REQ-011 CpuStop  in  1  CPU halt indication (HLT executed).
REQ-012 RamAddr  out  ADDR_W  programming-mode write address.
REQ-013 RamData  out  DATA_W  programming-mode write data.
REQ-014 RamWe  out  1  programming-mode write enable.
REQ-015 RunMode  out  1  RAM mux select: 0 = programming port, 1 = CPU run port.
REQ-016 CpuReset  out  1  reset to CPU core, active-high.
REQ-017 Busy  out  1  high in LOAD or ARM.
REQ-018 Done  out  1  one-cycle pulse when CPU is released into RUN.

Function
REQ-019 States SHALL be IDLE, LOAD, ARM, RUN, HALT.
REQ-020 IDLE: CpuReset=1, RunMode=0, InReady=0; Start=1 -> LOAD, LastAddr<=Count, Ptr<=0.
REQ-021 LOAD: InReady=1, RunMode=0, CpuReset=1; a beat is InValid&&InReady on a rising edge.
REQ-022 Each beat SHALL register RamAddr<=Ptr, RamData<=InData, RamWe<=1 (write visible one cycle after beat), then Ptr<=Ptr+1.
REQ-023 RamWe SHALL be 0 in every cycle not immediately following a beat; InValid gaps stall without writes.
REQ-024 Beat with Ptr==LastAddr SHALL be the final beat: -> ARM, InReady=0 from next cycle; Ptr never wraps (Count=15 loads 16 bytes, Count=0 loads 1).
REQ-025 ARM: RunMode=1, CpuReset=1 for exactly SETTLE_CYC cycles, then -> RUN.
REQ-026 RUN: RunMode=1, CpuReset=0; Done=1 for the first RUN cycle only; CpuStop=1 -> HALT next cycle.
REQ-027 HALT: RunMode=1, CpuReset=0, Busy=0; Start=1 -> LOAD (RunMode=0, CpuReset=1 from next cycle), Count relatched.
REQ-028 Start in LOAD, ARM or RUN SHALL be ignored; CpuStop outside RUN SHALL be ignored.
REQ-029 Start and CpuStop simultaneous in RUN: CpuStop wins (-> HALT), Start not retained.
REQ-030 InValid outside LOAD SHALL never produce a write; InReady=0 there.

Reset
REQ-031 Reset=1 SHALL immediately force IDLE, Ptr=0, LastAddr=0, RamAddr=0, RamData=0, RamWe=0, RunMode=0, CpuReset=1, InReady=0, Busy=0, Done=0.
REQ-032 Reset mid-LOAD SHALL abort the load with no further write; partial RAM contents are not cleared.
REQ-033 After Reset deasserts the block SHALL stay in IDLE until Start.

Structure
REQ-034 Package prog_loader_pkg SHALL hold the state enumeration and ADDR_W/DATA_W defaults.
REQ-035 Sub-module ld_addr_counter (load, clear, increment, last-flag compare against LastAddr) SHALL implement Ptr.
REQ-036 All outputs SHALL be registered except InReady and Busy, which decode from state.

Verification
REQ-037 Start, Count=15, 16 contiguous beats of Fibonacci image (0xBF,0x0E,0xE0,...,0x01) -> 16 writes addr 0..15 in order, ARM 1 cycle, Done pulse, CpuReset=0.
REQ-038 Count=3, InValid toggling 1/0 every cycle -> exactly 4 writes at addr 0..3, no RamWe during gaps.
REQ-039 Start pulses during LOAD and RUN -> no state change, Ptr unaffected.
REQ-040 CpuStop in RUN -> HALT with RunMode=1; then Start, Count=1 -> RunMode=0, CpuReset=1, 2 writes, rerun.
REQ-041 Reset asserted after 5th beat of a 16-byte load -> RamWe=0 and CpuReset=1 same cycle, IDLE, no further writes.
REQ-042 Count=0 -> single write at addr 0, then ARM -> RUN.
